// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// DATA-phase counter sizing.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } arb_state_t;

   localparam int MEM_LAT_MAX = 4;
   localparam int LAT_CW      = $clog2(MEM_LAT_MAX);

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from ptr+1 (mod NUM_REQ) and returns
// the first unmasked request as a one-hot vector plus its index.
module mem_arbiter_rr_pick
   import mem_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [IW-1:0]      win_idx,
   output logic               any
);

   logic [NUM_REQ-1:0] elig;
   logic [IW-1:0]      slot;

   always_comb begin
      elig    = req & ~mask;
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      slot    = '0;
      // k = NUM_REQ wraps back onto ptr itself, so it is considered last
      for (int k = 1; k <= NUM_REQ; k++) begin
         slot = IW'((int'(ptr) + k) % NUM_REQ);
         if (!any && elig[slot]) begin
            any        = 1'b1;
            win_idx    = slot;
            win[slot]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between NUM_REQ
// requesters; sequences addr_en -> in_en/out_en and returns a one-cycle ack.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int AW      = 16,
   parameter  int DW      = 16,
   parameter  int MEM_LAT = 1,
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    we,
   input  logic [NUM_REQ*AW-1:0] addr,
   input  logic [NUM_REQ*DW-1:0] wdata,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    ack,
   output logic [DW-1:0]         rdata,
   output logic                  mem_addr_en,
   output logic                  mem_in_en,
   output logic                  mem_out_en,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic [DW-1:0]         mem_rdata,
   output logic                  busy
);

   arb_state_t          state, state_nx;
   logic [LAT_CW-1:0]   cnt, cnt_nx;
   logic [IW-1:0]       idx, ptr, pick_ptr, pick_idx;
   logic [NUM_REQ-1:0]  pick_mask, pick_win;
   logic                pick_any, we_l, load;

   // In RESP the pointer is about to become idx and the served requester is
   // masked, so the next grant can be chosen without an IDLE bubble.
   assign pick_ptr  = (state == ST_RESP) ? idx : ptr;
   assign pick_mask = (state == ST_RESP) ? gnt : '0;

   mem_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (req),
      .mask    (pick_mask),
      .ptr     (pick_ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      load     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nx = ST_ADDR;
               load     = 1'b1;
            end
         end
         ST_ADDR: begin
            state_nx = ST_DATA;
            cnt_nx   = '0;
         end
         ST_DATA: begin
            if (cnt == LAT_CW'(MEM_LAT - 1)) state_nx = ST_RESP;
            else                             cnt_nx   = cnt + 1'b1;
         end
         ST_RESP: begin
            if (pick_any) begin
               state_nx = ST_ADDR;
               load     = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so every strobe is a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ptr         <= IW'(NUM_REQ - 1);
         idx         <= '0;
         we_l        <= 1'b0;
         gnt         <= '0;
         ack         <= '0;
         busy        <= 1'b0;
         mem_addr_en <= 1'b0;
         mem_in_en   <= 1'b0;
         mem_out_en  <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         rdata       <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         busy  <= (state_nx != ST_IDLE);
         if (state == ST_RESP) ptr <= idx;
         if (load) begin
            idx       <= pick_idx;
            we_l      <= we[pick_idx];
            gnt       <= pick_win;
            mem_addr  <= addr[int'(pick_idx)*AW +: AW];
            mem_wdata <= wdata[int'(pick_idx)*DW +: DW];
         end else if (state_nx == ST_IDLE) begin
            gnt <= '0;
         end
         ack         <= (state_nx == ST_RESP) ? gnt : '0;
         mem_addr_en <= (state_nx == ST_ADDR);
         mem_in_en   <= (state_nx == ST_DATA) && we_l && (cnt_nx == '0);
         mem_out_en  <= (state_nx == ST_DATA) && !we_l;
         if (state == ST_DATA && state_nx == ST_RESP && !we_l) rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mem_arbiter;

   localparam int NR = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NR-1:0]    req;
   logic [NR-1:0]    we;
   logic [NR*AW-1:0] addr;
   logic [NR*DW-1:0] wdata;
   logic [DW-1:0]    mem_rdata;

   logic [NR-1:0] gnt1, ack1, gnt3, ack3;
   logic [DW-1:0] rdata1, rdata3, mem_wdata1, mem_wdata3;
   logic [AW-1:0] mem_addr1, mem_addr3;
   logic          aen1, ien1, oen1, busy1;
   logic          aen3, ien3, oen3, busy3;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt1), .ack(ack1), .rdata(rdata1),
      .mem_addr_en(aen1), .mem_in_en(ien1), .mem_out_en(oen1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
      .busy(busy1)
   );

   mem_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt3), .ack(ack3), .rdata(rdata3),
      .mem_addr_en(aen3), .mem_in_en(ien3), .mem_out_en(oen3),
      .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata),
      .busy(busy3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;

      // Reset state
      step(1);
      chk("rst_strobes", {aen1, ien1, oen1}, 3'b000);
      chk("rst_gnt",     gnt1, 4'b0000);
      chk("rst_ack",     ack1, 4'b0000);
      chk("rst_busy",    busy1, 1'b0);
      chk("rst_rdata",   rdata1, 16'h0000);
      step(1);
      rst = 1'b1;
      step(1);

      // Single read from requester 2
      addr[2*AW +: AW] = 16'h0040;
      mem_rdata = 16'hBEEF;
      req = 4'b0100;
      step(1);
      chk("rd_c1_strobes", {aen1, ien1, oen1}, 3'b100);
      chk("rd_c1_gnt",     gnt1, 4'b0100);
      chk("rd_c1_addr",    mem_addr1, 16'h0040);
      chk("rd_c1_ack",     ack1, 4'b0000);
      step(1);
      chk("rd_c2_strobes", {aen1, ien1, oen1}, 3'b001);
      chk("rd_c2_ack",     ack1, 4'b0000);
      step(1);
      chk("rd_c3_ack",     ack1, 4'b0100);
      chk("rd_c3_strobes", {aen1, ien1, oen1}, 3'b000);
      chk("rd_c3_rdata",   rdata1, 16'hBEEF);
      chk("rd_c3_gnt",     gnt1, 4'b0100);
      req = 4'b0000;
      mem_rdata = 16'h0000;
      step(1);
      chk("rd_c4_busy", busy1, 1'b0);
      chk("rd_c4_gnt",  gnt1, 4'b0000);
      chk("rd_c4_ack",  ack1, 4'b0000);

      // Single write from requester 1; inputs change after grant
      addr[AW +: AW]  = 16'h0100;
      wdata[DW +: DW] = 16'h1234;
      we  = 4'b0010;
      req = 4'b0010;
      step(1);
      chk("wr_c1_strobes", {aen1, ien1, oen1}, 3'b100);
      chk("wr_c1_addr",    mem_addr1, 16'h0100);
      chk("wr_c1_gnt",     gnt1, 4'b0010);
      step(1);
      chk("wr_c2_strobes", {aen1, ien1, oen1}, 3'b010);
      chk("wr_c2_addr",    mem_addr1, 16'h0100);
      chk("wr_c2_wdata",   mem_wdata1, 16'h1234);
      addr[AW +: AW]  = 16'hFFFF;
      wdata[DW +: DW] = 16'hDEAD;
      we = 4'b0000;
      step(1);
      chk("wr_c3_strobes", {aen1, ien1, oen1}, 3'b000);
      chk("wr_c3_ack",     ack1, 4'b0010);
      chk("wr_c3_addr",    mem_addr1, 16'h0100);
      chk("wr_c3_rdata",   rdata1, 16'hBEEF);
      req = 4'b0000;
      step(1);
      chk("wr_c4_busy", busy1, 1'b0);

      // Reset in the middle of a read
      addr[0 +: AW] = 16'h0008;
      req = 4'b0001;
      step(2);
      chk("mr_data_strobes", {aen1, ien1, oen1}, 3'b001);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_strobes", {aen1, ien1, oen1}, 3'b000);
      chk("mr_gnt",     gnt1, 4'b0000);
      chk("mr_ack",     ack1, 4'b0000);
      chk("mr_busy",    busy1, 1'b0);
      step(1);
      rst = 1'b1;
      req = 4'b1111;

      // Round robin with all requests held, then masking of a held req[0]
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk($sformatf("rr%0d_gnt", k), gnt1, 32'(1 << (k % 4)));
         chk($sformatf("rr%0d_busy_a", k), busy1, 1'b1);
         if (k == 4) req = 4'b1001;
         step(1);
         chk($sformatf("rr%0d_busy_d", k), busy1, 1'b1);
         step(1);
         chk($sformatf("rr%0d_ack", k), ack1, 32'(1 << (k % 4)));
         chk($sformatf("rr%0d_busy_r", k), busy1, 1'b1);
      end
      step(1);
      chk("mask_gnt", gnt1, 4'b1000);
      req = 4'b0000;
      step(2);
      chk("mask_ack", ack1, 4'b1000);
      step(1);
      chk("mask_idle", busy1, 1'b0);

      // MEM_LAT=3 read; req dropped during DATA
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      addr[2*AW +: AW] = 16'h0040;
      we  = 4'b0000;
      req = 4'b0100;
      step(1);
      chk("l3_c1_strobes", {aen3, ien3, oen3}, 3'b100);
      chk("l3_c1_gnt",     gnt3, 4'b0100);
      step(1);
      chk("l3_c2_strobes", {aen3, ien3, oen3}, 3'b001);
      req = 4'b0000;
      mem_rdata = 16'h1111;
      step(1);
      chk("l3_c3_strobes", {aen3, ien3, oen3}, 3'b001);
      mem_rdata = 16'h2222;
      step(1);
      chk("l3_c4_strobes", {aen3, ien3, oen3}, 3'b001);
      chk("l3_c4_ack",     ack3, 4'b0000);
      mem_rdata = 16'hCAFE;
      step(1);
      chk("l3_c5_ack",     ack3, 4'b0100);
      chk("l3_c5_strobes", {aen3, ien3, oen3}, 3'b000);
      chk("l3_c5_rdata",   rdata3, 16'hCAFE);
      mem_rdata = 16'h0000;
      step(1);
      chk("l3_c6_busy",  busy3, 1'b0);
      chk("l3_c6_rdata", rdata3, 16'hCAFE);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
